jzjpcc_pipeline_control: RTL and testbench
==========================================

// Module: jzjpcc_pipeline_control
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core (fetch, decode, execute, memory, writeback).
//  Watches the decode and execute stages for load-use hazards, taken branches/jumps, memory-wait
//  and halt (ecall/ebreak). Drives per-stage stall/flush enables to the pipeline registers.
//  Runs a small FSM that drains the pipeline on halt. Keeps a saturating stall-cycle counter.
// PARAMETERS
//  STALL_CNT_W  default 32  width of the stall_count performance counter
// PORTS
//  clock                 in   1            core clock; all state on posedge
//  reset                 in   1            synchronous, active-high
//  rs1_decode            in   5            rs1 field of the instruction in decode
//  rs2_decode            in   5            rs2 field of the instruction in decode
//  rs1_used_decode       in   1            decode instruction reads rs1
//  rs2_used_decode       in   1            decode instruction reads rs2
//  halt_decode           in   1            decode instruction is ecall/ebreak
//  rd_execute            in   5            destination register of the instruction in execute
//  is_load_execute       in   1            execute instruction is a valid load
//  branch_taken_execute  in   1            execute resolved a taken branch/jal/jalr
//  mem_req_memory        in   1            memory stage has an outstanding data access
//  mem_ready_memory      in   1            data memory completes the access this cycle
//  stall_fetch           out  1            hold PC and fetch->decode register
//  stall_decode          out  1            hold decode->execute register
//  stall_execute         out  1            hold execute->memory register
//  stall_memory          out  1            hold memory->writeback register
//  flush_decode          out  1            load a bubble into decode
//  flush_execute         out  1            load a bubble into execute
//  halted                out  1            core stopped; high until reset
//  stall_count           out  STALL_CNT_W  cycles with stall_fetch=1, saturating
// BEHAVIOUR
//  - FSM states RUN, DRAIN, HALTED. Registered state. Outputs are Mealy: state plus current inputs.
//  - Reset: state=RUN, drain counter=0, stall_count=0.
//    In the reset cycle: flush_decode=flush_execute=1; all stall_*=0; halted=0.
//  - mem_wait = mem_req_memory & ~mem_ready_memory. In any state, mem_wait asserts all four stall_*
//    and forces both flushes to 0. No other event is acted on, and the drain counter does not move.
//  - Hazard test (sub-module): hazard = is_load_execute & rd_execute!=0 &
//    ((rs1_used_decode & rs1_decode==rd_execute) | (rs2_used_decode & rs2_decode==rd_execute)).
//  - RUN priority, applied when mem_wait=0:
//    1. branch_taken_execute: flush_decode=1 and flush_execute=1. No stall. Any hazard or halt is ignored.
//    2. hazard: stall_fetch=1, stall_decode=1, flush_execute=1 (one bubble).
//       Re-evaluated next cycle; the forwarded value is then available, so this is one cycle per hazard.
//    3. halt_decode: flush_decode=1. Next state DRAIN, drain counter=3.
//  - DRAIN: stall_fetch=1, stall_decode=1, flush_execute=1. Counter decrements when mem_wait=0.
//    At counter==1 with mem_wait=0, next state is HALTED. Inputs branch/hazard/halt are ignored.
//  - HALTED: halted=1, stall_fetch=1, stall_decode=1, flush_execute=1. Only reset exits.
//  - stall_count increments when stall_fetch=1 and state!=HALTED. It holds at all-ones.
//  - Reset mid-DRAIN or mid-mem_wait returns to RUN in the next cycle. No pending event survives reset.
// STRUCTURE
//  - jzjpcc_pkg: typedef enum logic [1:0] {RUN, DRAIN, HALTED} pipe_ctrl_state_t;
//    localparam HALT_DRAIN_CYCLES = 3; localparam logic [4:0] REG_X0 = 5'd0.
//  - Sub-module jzjpcc_hazard_detect: combinational load-use comparator. Ports are the rs/rd/used/load
//    inputs; output is hazard.
//  - Top: FSM, 2-bit drain counter, stall counter, output decode. Target ~150-250 lines.
// TESTING
//  - Load-use: is_load_execute=1, rd_execute=5, rs2_decode=5, rs2_used=1
//    -> 1 cycle stall_fetch=stall_decode=flush_execute=1; stall_count=1.
//  - x0/unused: rd_execute=0, or rs1 matches with rs1_used=0 -> no stall, no flush.
//  - Branch + hazard in the same cycle -> flush_decode=flush_execute=1, stall_fetch=0, stall_count unchanged.
//  - mem_req=1, mem_ready=0 for 4 cycles with branch_taken=1 -> all stall_*=1 and no flush for 4 cycles.
//    Branch flush follows on the cycle mem_ready=1.
//  - halt_decode=1 in RUN -> DRAIN for 3 cycles (5 if 2 mem_wait cycles are inserted).
//    Then halted=1 stays held; after reset, halted=0 and stall_count=0.
//  - Reset asserted mid-DRAIN -> next cycle state RUN, halted=0. Reset cycle shows flushes=1, stalls=0.

Source files
------------

// File: rtl/jzjpcc_pkg.sv
// Shared types and constants for the pipeline control block.
//   pipe_ctrl_state_t  : control FSM states (RUN, DRAIN, HALTED)
//   HALT_DRAIN_CYCLES  : cycles spent draining after a halt instruction leaves decode
//   REG_X0             : architectural zero register, never a real hazard source
package jzjpcc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_ctrl_state_t;

  localparam int unsigned HALT_DRAIN_CYCLES = 3;
  localparam logic [4:0]  REG_X0 = 5'd0;

endpackage

// File: rtl/jzjpcc_pipeline_control_if.sv
// Bundle between the pipeline datapath and the pipeline control block.
//   Decode-stage info : rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode, halt_decode
//   Execute-stage info: rd_execute, is_load_execute, branch_taken_execute
//   Memory handshake  : mem_req_memory, mem_ready_memory
//   Controls          : stall_fetch/decode/execute/memory, flush_decode/execute
// Modport master is the control block (drives controls); slave is the datapath.
interface jzjpcc_pipeline_control_if;

  logic [4:0] rs1_decode;
  logic [4:0] rs2_decode;
  logic       rs1_used_decode;
  logic       rs2_used_decode;
  logic       halt_decode;
  logic [4:0] rd_execute;
  logic       is_load_execute;
  logic       branch_taken_execute;
  logic       mem_req_memory;
  logic       mem_ready_memory;
  logic       stall_fetch;
  logic       stall_decode;
  logic       stall_execute;
  logic       stall_memory;
  logic       flush_decode;
  logic       flush_execute;

  modport master (
    input  rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode, halt_decode,
    input  rd_execute, is_load_execute, branch_taken_execute,
    input  mem_req_memory, mem_ready_memory,
    output stall_fetch, stall_decode, stall_execute, stall_memory,
    output flush_decode, flush_execute
  );

  modport slave (
    output rs1_decode, rs2_decode, rs1_used_decode, rs2_used_decode, halt_decode,
    output rd_execute, is_load_execute, branch_taken_execute,
    output mem_req_memory, mem_ready_memory,
    input  stall_fetch, stall_decode, stall_execute, stall_memory,
    input  flush_decode, flush_execute
  );

endinterface

// File: rtl/jzjpcc_hazard_detect.sv
// Combinational load-use hazard comparator.
//   rs1/rs2, rs1_used/rs2_used : source registers of the decode instruction
//   rd, is_load                : destination and load flag of the execute instruction
//   hazard                     : decode needs a value the execute load has not produced yet
module jzjpcc_hazard_detect
  import jzjpcc_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd,
  input  logic       is_load,
  output logic       hazard
);

  // Writes to x0 are discarded, so a load targeting x0 can never feed a consumer.
  assign hazard = is_load && (rd != REG_X0) &&
                  ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));

endmodule

// File: rtl/jzjpcc_pipeline_control.sv
// Central stall/flush sequencer for the 5-stage core.
//   clock, reset : core clock, synchronous active-high reset
//   pipe         : datapath bundle (hazard/branch/halt/memory inputs, stall/flush outputs)
//   halted       : core stopped, held until reset
//   stall_count  : saturating count of cycles with stall_fetch set (HALTED cycles excluded)
module jzjpcc_pipeline_control
  import jzjpcc_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  jzjpcc_pipeline_control_if.master   pipe,
  output logic                        halted,
  output logic [STALL_CNT_W-1:0]      stall_count
);

  pipe_ctrl_state_t state, state_next;
  logic [1:0]       drain_cnt, drain_next;
  logic             hazard;
  logic             mem_wait;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e;

  jzjpcc_hazard_detect hazard_unit (
    .rs1      (pipe.rs1_decode),
    .rs2      (pipe.rs2_decode),
    .rs1_used (pipe.rs1_used_decode),
    .rs2_used (pipe.rs2_used_decode),
    .rd       (pipe.rd_execute),
    .is_load  (pipe.is_load_execute),
    .hazard   (hazard)
  );

  assign mem_wait = pipe.mem_req_memory && !pipe.mem_ready_memory;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      drain_cnt   <= 2'd0;
      stall_count <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      if (stall_f && (state != HALTED) && !(&stall_count))
        stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  // Reset outranks everything and presents bubbles; a memory wait freezes the
  // whole pipe and defers every other event until the access completes.
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      halted = (state == HALTED);
      if (mem_wait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else begin
        unique case (state)
          RUN: begin
            if (pipe.branch_taken_execute) begin
              flush_d = 1'b1;
              flush_e = 1'b1;
            end else if (hazard) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              flush_e = 1'b1;
            end else if (pipe.halt_decode) begin
              flush_d    = 1'b1;
              state_next = DRAIN;
              drain_next = 2'(HALT_DRAIN_CYCLES);
            end
          end
          DRAIN: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            if (drain_cnt == 2'd1) begin
              state_next = HALTED;
              drain_next = 2'd0;
            end else begin
              drain_next = drain_cnt - 2'd1;
            end
          end
          HALTED: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
          default: begin
            state_next = RUN;
            drain_next = 2'd0;
          end
        endcase
      end
    end
  end

  assign pipe.stall_fetch   = stall_f;
  assign pipe.stall_decode  = stall_d;
  assign pipe.stall_execute = stall_e;
  assign pipe.stall_memory  = stall_m;
  assign pipe.flush_decode  = flush_d;
  assign pipe.flush_execute = flush_e;

endmodule

// File: tb/tb_jzjpcc_pipeline_control.sv
// Directed bench for jzjpcc_pipeline_control. Each step drives one cycle of
// inputs, pushes the hand-derived expected outputs onto a scoreboard queue,
// then pops and compares them mid-cycle.
module tb_jzjpcc_pipeline_control;

  localparam int CW = 4;

  typedef struct packed {
    logic       reset;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       halt;
    logic [4:0] rd;
    logic       is_load;
    logic       branch;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  typedef struct {
    string       tag;
    logic [3:0]  stalls;
    logic [1:0]  flushes;
    logic        halted;
    logic [CW-1:0] count;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          halted;
  logic [CW-1:0] stall_count;
  exp_t          sb_q[$];
  int            pass_count = 0;
  int            total_count = 0;

  jzjpcc_pipeline_control_if pipe ();

  jzjpcc_pipeline_control #(.STALL_CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .pipe        (pipe.master),
    .halted      (halted),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drive one cycle of inputs and queue what the control block must show.
  task automatic apply_stimulus(input stim_t s, input string tag, input logic [3:0] stalls,
                                input logic [1:0] flushes, input logic hlt, input logic [CW-1:0] cnt);
    exp_t e;
    reset                     = s.reset;
    pipe.rs1_decode           = s.rs1;
    pipe.rs2_decode           = s.rs2;
    pipe.rs1_used_decode      = s.rs1_used;
    pipe.rs2_used_decode      = s.rs2_used;
    pipe.halt_decode          = s.halt;
    pipe.rd_execute           = s.rd;
    pipe.is_load_execute      = s.is_load;
    pipe.branch_taken_execute = s.branch;
    pipe.mem_req_memory       = s.mem_req;
    pipe.mem_ready_memory     = s.mem_ready;
    e.tag     = tag;
    e.stalls  = stalls;
    e.flushes = flushes;
    e.halted  = hlt;
    e.count   = cnt;
    sb_q.push_back(e);
  endtask

  // Sample mid-cycle, compare against the oldest queued expectation, advance.
  task automatic check_output();
    exp_t e;
    logic [3:0] obs_stalls;
    logic [1:0] obs_flushes;
    #3;
    obs_stalls  = {pipe.stall_fetch, pipe.stall_decode, pipe.stall_execute, pipe.stall_memory};
    obs_flushes = {pipe.flush_decode, pipe.flush_execute};
    total_count++;
    assert (sb_q.size() > 0) pass_count++;
    else $error("[TB] FAIL scoreboard_empty observed=0 expected=entry");
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total_count++;
      assert (obs_stalls === e.stalls) pass_count++;
      else $error("[TB] FAIL %s.stalls observed=%b expected=%b", e.tag, obs_stalls, e.stalls);
      total_count++;
      assert (obs_flushes === e.flushes) pass_count++;
      else $error("[TB] FAIL %s.flushes observed=%b expected=%b", e.tag, obs_flushes, e.flushes);
      total_count++;
      assert (halted === e.halted) pass_count++;
      else $error("[TB] FAIL %s.halted observed=%b expected=%b", e.tag, halted, e.halted);
      total_count++;
      assert (stall_count === e.count) pass_count++;
      else $error("[TB] FAIL %s.stall_count observed=%0d expected=%0d", e.tag, stall_count, e.count);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    stim_t s;
    s = idle();
    s.reset = 1'b1;
    apply_stimulus(s, "pre_reset", 4'b0000, 2'b11, 1'b0, '0);
    sb_q.delete();
    @(posedge clock);
    #1;

    s = idle(); s.reset = 1'b1;
    apply_stimulus(s, "reset_cycle", 4'b0000, 2'b11, 1'b0, 4'd0); check_output();
    s = idle();
    apply_stimulus(s, "idle_after_reset", 4'b0000, 2'b00, 1'b0, 4'd0); check_output();

    s = idle(); s.is_load = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.rs2_used = 1;
    apply_stimulus(s, "load_use_rs2", 4'b1100, 2'b01, 1'b0, 4'd0); check_output();
    s = idle();
    apply_stimulus(s, "after_load_use", 4'b0000, 2'b00, 1'b0, 4'd1); check_output();

    s = idle(); s.is_load = 1; s.rd = 5'd0; s.rs1 = 5'd0; s.rs1_used = 1;
    apply_stimulus(s, "load_x0", 4'b0000, 2'b00, 1'b0, 4'd1); check_output();
    s = idle(); s.is_load = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.rs2 = 5'd3; s.rs2_used = 1;
    apply_stimulus(s, "rs1_unused", 4'b0000, 2'b00, 1'b0, 4'd1); check_output();
    s = idle(); s.is_load = 1; s.rd = 5'd9; s.rs1 = 5'd9; s.rs1_used = 1;
    apply_stimulus(s, "load_use_rs1", 4'b1100, 2'b01, 1'b0, 4'd1); check_output();

    s = idle(); s.is_load = 1; s.rd = 5'd9; s.rs1 = 5'd9; s.rs1_used = 1; s.branch = 1;
    apply_stimulus(s, "branch_over_hazard", 4'b0000, 2'b11, 1'b0, 4'd2); check_output();
    s = idle();
    apply_stimulus(s, "idle_after_branch", 4'b0000, 2'b00, 1'b0, 4'd2); check_output();

    for (int i = 0; i < 4; i++) begin
      s = idle(); s.mem_req = 1; s.branch = 1;
      apply_stimulus(s, "mem_wait_branch", 4'b1111, 2'b00, 1'b0, CW'(2 + i)); check_output();
    end
    s = idle(); s.mem_req = 1; s.mem_ready = 1; s.branch = 1;
    apply_stimulus(s, "mem_ready_branch", 4'b0000, 2'b11, 1'b0, 4'd6); check_output();
    s = idle();
    apply_stimulus(s, "idle_after_mem", 4'b0000, 2'b00, 1'b0, 4'd6); check_output();

    s = idle(); s.halt = 1;
    apply_stimulus(s, "halt_in_run", 4'b0000, 2'b10, 1'b0, 4'd6); check_output();
    s = idle(); s.branch = 1;
    apply_stimulus(s, "drain_3_branch_ignored", 4'b1100, 2'b01, 1'b0, 4'd6); check_output();
    s = idle(); s.mem_req = 1;
    apply_stimulus(s, "drain_mem_wait_a", 4'b1111, 2'b00, 1'b0, 4'd7); check_output();
    apply_stimulus(s, "drain_mem_wait_b", 4'b1111, 2'b00, 1'b0, 4'd8); check_output();
    s = idle();
    apply_stimulus(s, "drain_2", 4'b1100, 2'b01, 1'b0, 4'd9); check_output();
    s = idle(); s.halt = 1;
    apply_stimulus(s, "drain_1_halt_ignored", 4'b1100, 2'b01, 1'b0, 4'd10); check_output();
    s = idle();
    apply_stimulus(s, "halted_a", 4'b1100, 2'b01, 1'b1, 4'd11); check_output();
    s = idle(); s.mem_req = 1;
    apply_stimulus(s, "halted_mem_wait", 4'b1111, 2'b00, 1'b1, 4'd11); check_output();
    s = idle(); s.branch = 1;
    apply_stimulus(s, "halted_b", 4'b1100, 2'b01, 1'b1, 4'd11); check_output();

    s = idle(); s.reset = 1;
    apply_stimulus(s, "reset_from_halted", 4'b0000, 2'b11, 1'b0, 4'd11); check_output();
    s = idle();
    apply_stimulus(s, "run_after_halt_reset", 4'b0000, 2'b00, 1'b0, 4'd0); check_output();

    s = idle(); s.halt = 1;
    apply_stimulus(s, "halt_again", 4'b0000, 2'b10, 1'b0, 4'd0); check_output();
    s = idle();
    apply_stimulus(s, "drain_before_reset", 4'b1100, 2'b01, 1'b0, 4'd0); check_output();
    s = idle(); s.reset = 1; s.mem_req = 1;
    apply_stimulus(s, "reset_mid_drain", 4'b0000, 2'b11, 1'b0, 4'd1); check_output();
    s = idle();
    apply_stimulus(s, "run_after_drain_reset", 4'b0000, 2'b00, 1'b0, 4'd0); check_output();
    s = idle(); s.is_load = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.rs2_used = 1;
    apply_stimulus(s, "load_use_after_reset", 4'b1100, 2'b01, 1'b0, 4'd0); check_output();

    // Counter saturation: a long memory wait pushes stall_count past all-ones.
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.mem_req = 1;
      apply_stimulus(s, "saturate", 4'b1111, 2'b00, 1'b0, (i >= 14) ? 4'd15 : CW'(1 + i));
      check_output();
    end
    s = idle();
    apply_stimulus(s, "saturated_hold", 4'b0000, 2'b00, 1'b0, 4'd15); check_output();

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
